// File: rtl/scc_pkg.sv
// rtl/scc_pkg.sv - shared constants for the commit stage and branch condition logic
package scc_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational condition-code evaluation against a flag set
module branch_cond_eval
  import scc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n, c, z, v;

  assign n = flags[FLAG_N];
  assign c = flags[FLAG_C];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];

  // Decode the condition against the supplied flags
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_CS: taken = c;
      COND_CC: taken = ~c;
      COND_MI: taken = n;
      COND_PL: taken = ~n;
      COND_VS: taken = v;
      COND_VC: taken = ~v;
      COND_HI: taken = c & ~z;
      COND_LS: taken = ~(c & ~z);
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = ~z & (n == v);
      COND_LE: taken = ~(~z & (n == v));
      COND_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_commit_stage.sv
// rtl/wb_commit_stage.sv - commit stage: register write, CPSR, branch redirect and shadow squash
module wb_commit_stage
  import scc_pkg::*;
#(
  parameter int         SHADOW_SLOTS = 2,
  parameter logic [3:0] RESET_FLAGS  = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [32:0] ex_result,
  input  logic [3:0]  ex_flags,
  input  logic        ex_flags_update,
  input  logic        ex_w_enable,
  input  logic [2:0]  ex_dest_reg,
  input  logic        ex_is_branch,
  input  logic [3:0]  ex_b_cond,
  input  logic [31:0] ex_branch_target,
  input  logic        ex_is_halt,
  input  logic        wb_stall,
  output logic        rf_w_enable,
  output logic [2:0]  rf_w_addr,
  output logic [31:0] rf_w_data,
  output logic [3:0]  cpsr,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        flush,
  output logic        halted
);

  state_t      state, state_next;
  logic [2:0]  squash_cnt, squash_cnt_next;
  logic        accept;
  logic        cond_taken;

  logic        rf_w_enable_next;
  logic [2:0]  rf_w_addr_next;
  logic [31:0] rf_w_data_next;
  logic [3:0]  cpsr_next;
  logic        pc_load_next;
  logic [31:0] pc_target_next;

  // The carry/overflow bit travels with the result but the register file is 32 bits wide
  logic carry_unused;
  assign carry_unused = ex_result[32];

  assign ex_ready = ~wb_stall & (state != ST_HALT);
  assign accept   = ex_valid & ex_ready;
  assign halted   = (state == ST_HALT);

  // Branches resolve against the committed flags, which already include the previous instruction
  branch_cond_eval u_cond (
    .cond  (ex_b_cond),
    .flags (cpsr),
    .taken (cond_taken)
  );

  // Next-state and next-output decode; pulses default low, captured values hold
  always_comb begin
    state_next       = state;
    squash_cnt_next  = squash_cnt;
    rf_w_enable_next = 1'b0;
    rf_w_addr_next   = rf_w_addr;
    rf_w_data_next   = rf_w_data;
    cpsr_next        = cpsr;
    pc_load_next     = 1'b0;
    pc_target_next   = pc_target;
    if (accept) begin
      case (state)
        ST_RUN: begin
          if (ex_is_halt) begin
            state_next = ST_HALT;
          end else if (ex_is_branch) begin
            if (cond_taken) begin
              pc_load_next    = 1'b1;
              pc_target_next  = ex_branch_target;
              squash_cnt_next = 3'(SHADOW_SLOTS);
              state_next      = ST_SQUASH;
            end
          end else begin
            rf_w_enable_next = ex_w_enable;
            if (ex_w_enable) begin
              rf_w_addr_next = ex_dest_reg;
              rf_w_data_next = ex_result[31:0];
            end
            if (ex_flags_update) begin
              cpsr_next = ex_flags;
            end
          end
        end
        ST_SQUASH: begin
          squash_cnt_next = squash_cnt - 3'd1;
          if (squash_cnt == 3'd1) begin
            state_next = ST_RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      squash_cnt  <= 3'd0;
      rf_w_enable <= 1'b0;
      rf_w_addr   <= 3'd0;
      rf_w_data   <= 32'd0;
      cpsr        <= RESET_FLAGS;
      pc_load     <= 1'b0;
      flush       <= 1'b0;
      pc_target   <= 32'd0;
    end else begin
      state       <= state_next;
      squash_cnt  <= squash_cnt_next;
      rf_w_enable <= rf_w_enable_next;
      rf_w_addr   <= rf_w_addr_next;
      rf_w_data   <= rf_w_data_next;
      cpsr        <= cpsr_next;
      pc_load     <= pc_load_next;
      flush       <= pc_load_next;
      pc_target   <= pc_target_next;
    end
  end

endmodule

// File: tb/tb_wb_commit_stage.sv
// tb/tb_wb_commit_stage.sv - self-checking bench for wb_commit_stage
module tb_wb_commit_stage;

  localparam int         SHADOW = 2;
  localparam logic [3:0] RSTF   = 4'b0000;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [32:0] ex_result;
  logic [3:0]  ex_flags;
  logic        ex_flags_update;
  logic        ex_w_enable;
  logic [2:0]  ex_dest_reg;
  logic        ex_is_branch;
  logic [3:0]  ex_b_cond;
  logic [31:0] ex_branch_target;
  logic        ex_is_halt;
  logic        wb_stall;
  logic        rf_w_enable;
  logic [2:0]  rf_w_addr;
  logic [31:0] rf_w_data;
  logic [3:0]  cpsr;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        flush;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0]  m_cpsr;
  int          m_sq;
  bit          m_halt;
  bit          exp_we;
  logic [2:0]  exp_addr;
  logic [31:0] exp_data;
  bit          exp_pl;
  logic [31:0] exp_tgt;

  wb_commit_stage #(.SHADOW_SLOTS(SHADOW), .RESET_FLAGS(RSTF)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_valid         (ex_valid),
    .ex_ready         (ex_ready),
    .ex_result        (ex_result),
    .ex_flags         (ex_flags),
    .ex_flags_update  (ex_flags_update),
    .ex_w_enable      (ex_w_enable),
    .ex_dest_reg      (ex_dest_reg),
    .ex_is_branch     (ex_is_branch),
    .ex_b_cond        (ex_b_cond),
    .ex_branch_target (ex_branch_target),
    .ex_is_halt       (ex_is_halt),
    .wb_stall         (wb_stall),
    .rf_w_enable      (rf_w_enable),
    .rf_w_addr        (rf_w_addr),
    .rf_w_data        (rf_w_data),
    .cpsr             (cpsr),
    .pc_load          (pc_load),
    .pc_target        (pc_target),
    .flush            (flush),
    .halted           (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, cy, z, v;
    n = f[3]; cy = f[2]; z = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !(cy && !z);
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return !(!z && (n == v));
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nop();
    ex_valid = 0; ex_result = '0; ex_flags = '0; ex_flags_update = 0;
    ex_w_enable = 0; ex_dest_reg = '0; ex_is_branch = 0; ex_b_cond = '0;
    ex_branch_target = '0; ex_is_halt = 0; wb_stall = 0;
  endtask

  task automatic set_alu(input logic [2:0] d, input logic [31:0] r, input logic [3:0] f, input bit fu);
    nop();
    ex_valid = 1; ex_w_enable = 1; ex_dest_reg = d; ex_result = {1'b0, r};
    ex_flags = f; ex_flags_update = fu;
  endtask

  task automatic set_br(input logic [3:0] c, input logic [31:0] t);
    nop();
    ex_valid = 1; ex_is_branch = 1; ex_b_cond = c; ex_branch_target = t;
    ex_w_enable = 1; ex_flags_update = 1; ex_flags = 4'hF;
  endtask

  task automatic model_reset();
    m_cpsr = RSTF; m_sq = 0; m_halt = 0; exp_we = 0; exp_pl = 0;
    exp_addr = '0; exp_data = '0; exp_tgt = '0;
  endtask

  // One clock: check ready, advance the model, then compare registered outputs
  task automatic step();
    bit acc;
    #1;
    chk("ex_ready", {31'd0, ex_ready}, {31'd0, !wb_stall && !m_halt});
    acc = ex_valid && !wb_stall && !m_halt;
    exp_we = 0;
    exp_pl = 0;
    if (acc) begin
      if (m_sq > 0) begin
        m_sq--;
      end else if (ex_is_halt) begin
        m_halt = 1;
      end else if (ex_is_branch) begin
        if (cond_ok(ex_b_cond, m_cpsr)) begin
          exp_pl = 1; exp_tgt = ex_branch_target; m_sq = SHADOW;
        end
      end else begin
        exp_we = ex_w_enable;
        exp_addr = ex_dest_reg;
        exp_data = ex_result[31:0];
        if (ex_flags_update) m_cpsr = ex_flags;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("rf_w_enable", {31'd0, rf_w_enable}, {31'd0, exp_we});
    if (exp_we) begin
      chk("rf_w_addr", {29'd0, rf_w_addr}, {29'd0, exp_addr});
      chk("rf_w_data", rf_w_data, exp_data);
    end
    chk("pc_load", {31'd0, pc_load}, {31'd0, exp_pl});
    chk("flush", {31'd0, flush}, {31'd0, exp_pl});
    if (exp_pl) chk("pc_target", pc_target, exp_tgt);
    chk("cpsr", {28'd0, cpsr}, {28'd0, m_cpsr});
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
  endtask

  task automatic do_reset();
    nop();
    rst_n = 0;
    #1;
    model_reset();
    chk("rst_rf_w_enable", {31'd0, rf_w_enable}, 32'd0);
    chk("rst_rf_w_addr", {29'd0, rf_w_addr}, 32'd0);
    chk("rst_rf_w_data", rf_w_data, 32'd0);
    chk("rst_pc_load", {31'd0, pc_load}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_pc_target", pc_target, 32'd0);
    chk("rst_cpsr", {28'd0, cpsr}, {28'd0, RSTF});
    chk("rst_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    nop();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // 1: ADD commits
    set_alu(3'd3, 32'h2A, 4'b0000, 1); step();
    chk("t1_we", {31'd0, rf_w_enable}, 32'd1);
    chk("t1_addr", {29'd0, rf_w_addr}, 32'd3);
    chk("t1_data", rf_w_data, 32'h2A);
    chk("t1_cpsr", {28'd0, cpsr}, 32'd0);

    // 2: SUB sets Z, BEQ taken, two shadow transfers dropped, third commits
    set_alu(3'd1, 32'd0, 4'b0010, 1); step();
    set_br(4'h0, 32'h40); step();
    chk("t2_pc_load", {31'd0, pc_load}, 32'd1);
    chk("t2_flush", {31'd0, flush}, 32'd1);
    chk("t2_target", pc_target, 32'h40);
    chk("t2_cpsr", {28'd0, cpsr}, 32'h2);
    set_alu(3'd5, 32'h11, 4'b1000, 1); step();
    chk("t2_sq1", {31'd0, rf_w_enable}, 32'd0);
    set_alu(3'd5, 32'h22, 4'b1000, 1); step();
    chk("t2_sq2", {31'd0, rf_w_enable}, 32'd0);
    set_alu(3'd6, 32'h33, 4'b0000, 0); step();
    chk("t2_commit", {31'd0, rf_w_enable}, 32'd1);
    chk("t2_commit_data", rf_w_data, 32'h33);

    // 3: BNE with Z=1 not taken
    set_br(4'h1, 32'h80); step();
    chk("t3_no_load", {31'd0, pc_load}, 32'd0);
    set_alu(3'd2, 32'h55, 4'b0000, 0); step();
    chk("t3_commit", {31'd0, rf_w_enable}, 32'd1);

    // 4: sweep all conditions against all flag values
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        set_alu(3'd0, 32'(f), 4'(f), 1); step();
        set_br(4'(c), 32'(c * 256 + f * 4)); step();
        if (c == 14) chk("t4_al", {31'd0, pc_load}, 32'd1);
        if (c == 15) chk("t4_nv", {31'd0, pc_load}, 32'd0);
        if (pc_load) begin
          nop(); ex_valid = 1; step(); step();
        end
      end
    end
    chk("t4_ge_pin", {31'd0, cond_ok(4'hA, 4'b1000)}, 32'd0);
    chk("t4_hi_pin", {31'd0, cond_ok(4'h8, 4'b0100)}, 32'd1);

    // 5: stall holds the transfer; commits once after release
    for (int i = 0; i < 3; i++) begin
      set_alu(3'd4, 32'h77, 4'b0001, 1); wb_stall = 1; step();
      chk("t5_stall_we", {31'd0, rf_w_enable}, 32'd0);
    end
    set_alu(3'd4, 32'h77, 4'b0001, 1); step();
    chk("t5_release", {31'd0, rf_w_enable}, 32'd1);
    nop(); step();
    chk("t5_once", {31'd0, rf_w_enable}, 32'd0);
    set_br(4'hE, 32'h100); step();
    for (int i = 0; i < 3; i++) begin
      set_alu(3'd7, 32'h99, 4'b0000, 0); wb_stall = 1; step();
    end
    set_alu(3'd7, 32'h99, 4'b0000, 0); step();
    chk("t5_sq_a", {31'd0, rf_w_enable}, 32'd0);
    step();
    chk("t5_sq_b", {31'd0, rf_w_enable}, 32'd0);
    step();
    chk("t5_sq_commit", {31'd0, rf_w_enable}, 32'd1);

    // 6: reset during squash with one slot left, then halt
    set_alu(3'd1, 32'h1, 4'b1111, 1); step();
    set_br(4'hE, 32'h200); step();
    nop(); ex_valid = 1; step();
    do_reset();
    set_alu(3'd2, 32'hBEEF, 4'b0100, 1); step();
    chk("t6_commit", {31'd0, rf_w_enable}, 32'd1);
    chk("t6_cpsr", {28'd0, cpsr}, 32'h4);
    nop(); ex_valid = 1; ex_is_halt = 1; step();
    chk("t6_halted", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      set_alu(3'd3, 32'h5, 4'b0000, 1); step();
      chk("t6_halt_ready", {31'd0, ex_ready}, 32'd0);
    end
    do_reset();

    // Randomized traffic against the model
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 250; i++) begin
        ex_valid         = ($urandom_range(0, 3) != 0);
        wb_stall         = ($urandom_range(0, 5) == 0);
        ex_is_branch     = ($urandom_range(0, 3) == 0);
        ex_is_halt       = ($urandom_range(0, 199) == 0);
        ex_b_cond        = 4'($urandom);
        ex_flags         = 4'($urandom);
        ex_flags_update  = 1'($urandom);
        ex_w_enable      = 1'($urandom);
        ex_dest_reg      = 3'($urandom);
        ex_result        = {1'($urandom), 32'($urandom)};
        ex_branch_target = 32'($urandom);
        step();
      end
      do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
